// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, datapath widths
// and the 3-bit opcode map.
package alu_arb_pkg;

  localparam int ALU_W = 8;
  localparam int OP_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU. Carry is the add carry-out or the subtract borrow;
// logic and shift ops clear it.
module alu
  import alu_arb_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [ALU_W-1:0] result,
  output logic             zero,
  output logic             carry
);

  logic [ALU_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~a};
      OP_SHL:  wide = {1'b0, a[ALU_W-2:0], 1'b0};
      OP_SHR:  wide = {2'b00, a[ALU_W-1:1]};
      default: wide = '0;
    endcase
  end

  assign result = wide[ALU_W-1:0];
  assign carry  = wide[ALU_W];
  assign zero   = (result == '0);

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational winner select. Round-robin from last_grant+1 by default;
// with ALU_ARB_FIXED_PRIO_EN defined the lowest valid index always wins.
module alu_rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] start;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
  // Starting "after" the top index makes the scan begin at requester 0.
  assign start = IDW'(NREQ-1);
`else
  assign start = last_grant;
`endif

  always_comb begin
    logic [IDW-1:0] idx;
    logic           found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = start;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ-1)) ? '0 : idx + 1'b1;
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters; responses are tagged with the requester id.
// Arbitration policy is selected by ALU_ARB_FIXED_PRIO_EN (see alu_rr_pick).
//
//   state | meaning
//   IDLE  | offer ready to the arbitration winner, latch its operands on handshake
//   EXEC  | ALU runs on latched operands, result registered into rsp_*
//   RESP  | rsp_valid held with stable data until rsp_ready
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  input  logic [OP_W*NREQ-1:0]  req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_carry
);

  state_t            state, state_nxt;
  logic [IDW-1:0]    last_grant, grant_idx, lat_id;
  logic [NREQ-1:0]   grant;
  logic [ALU_W-1:0]  lat_a, lat_b, alu_result;
  logic [OP_W-1:0]   lat_op;
  logic              alu_zero, alu_carry;

  logic [ALU_W-1:0]  a_arr  [NREQ];
  logic [ALU_W-1:0]  b_arr  [NREQ];
  logic [OP_W-1:0]   op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[ALU_W*i +: ALU_W];
    assign b_arr[i]  = req_b[ALU_W*i +: ALU_W];
    assign op_arr[i] = req_op[OP_W*i +: OP_W];
  end

  alu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  alu u_alu (
    .a      (lat_a),
    .b      (lat_b),
    .op     (lat_op),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ready is masked during reset so nothing is offered while the FSM is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (!rst) req_ready = grant;
        if (|req_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NREQ-1);
      lat_id     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            lat_a      <= a_arr[grant_idx];
            lat_b      <= b_arr[grant_idx];
            lat_op     <= op_arr[grant_idx];
            lat_id     <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= lat_id;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_carry  <= alu_carry;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table-driven single ops plus sequences for
// arbitration order, response back-pressure, operand isolation and mid-op reset.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [ALU_W*NREQ-1:0] req_a;
  logic [ALU_W*NREQ-1:0] req_b;
  logic [OP_W*NREQ-1:0]  req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ALU_W-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  rsp_carry;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry)
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       z;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op);
    exp_t       e;
    logic [8:0] w;
    case (op)
      3'b000:  w = 9'(a) + 9'(b);
      3'b001:  w = 9'(a) - 9'(b);
      3'b010:  w = {1'b0, a & b};
      3'b011:  w = {1'b0, a | b};
      3'b100:  w = {1'b0, a ^ b};
      3'b101:  w = {1'b0, ~a};
      3'b110:  w = {1'b0, a[6:0], 1'b0};
      default: w = {2'b00, a[7:1]};
    endcase
    e.id  = id;
    e.res = w[7:0];
    e.c   = w[8];
    e.z   = (w[7:0] == 8'h00);
    return e;
  endfunction

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    req_op[id*3 +: 3] = op;
  endtask

  // Called at a falling edge after inputs change; returns the granted index or -1.
  task automatic wait_grant(output int gid);
    gid = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        break;
      end
      @(negedge clk);
    end
    if (gid < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no req_ready, expected a grant (t=%0t)", $time);
    end
  endtask

  // Drives one request, completes the handshake, returns at the falling edge in EXEC.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input exp_t e);
    int gid;
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    wait_grant(gid);
    chk("grant_id", 32'(gid), 32'(id));
    if (gid >= 0) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  // Entered at the falling edge one cycle after the handshake.
  task automatic check_rsp();
    int   lat;
    exp_t e;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'd2);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got a response, expected none queued (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_result", 32'(rsp_result), 32'(e.res));
      chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
      chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
    end
  endtask

  task automatic accept_rsp();
    @(posedge clk);
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[11];
    int         gids[4];
    int         exp_g[4];
    int         gid;
    exp_t       e0, e1;
    logic [11:0] snap;

    vecs[0]  = '{0, 8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{1, 8'h05, 8'h07, 3'b001, 8'hFE, 1'b0, 1'b1};
    vecs[2]  = '{0, 8'h12, 8'h34, 3'b000, 8'h46, 1'b0, 1'b0};
    vecs[3]  = '{1, 8'hF0, 8'h0F, 3'b010, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{0, 8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'hAA, 8'hFF, 3'b100, 8'h55, 1'b0, 1'b0};
    vecs[6]  = '{0, 8'h0F, 8'h00, 3'b101, 8'hF0, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h81, 8'h00, 3'b110, 8'h02, 1'b0, 1'b0};
    vecs[8]  = '{0, 8'h01, 8'h00, 3'b111, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1, 8'h07, 8'h07, 3'b001, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1};

`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", {19'd0, rsp_id, rsp_result, rsp_zero, rsp_carry, 2'b00}, 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;

    // Single-requester operations covering every opcode.
    foreach (vecs[i]) begin
      exp_t e;
      e.id  = vecs[i].id;
      e.res = vecs[i].res;
      e.z   = vecs[i].z;
      e.c   = vecs[i].c;
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, e);
      check_rsp();
      accept_rsp();
    end

    // Both requesters pending every cycle: grant order after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 8'h01, 8'h02, 3'b000);
    set_req(1, 8'h10, 8'h01, 3'b001);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_grant(gid);
      gids[g] = gid;
      if (gid < 0) break;
      sb.push_back(model(gid, req_a[gid*8 +: 8], req_b[gid*8 +: 8], req_op[gid*3 +: 3]));
      @(posedge clk);
      @(negedge clk);
      check_rsp();
      accept_rsp();
    end
    req_valid = '0;
    for (int g = 0; g < 4; g++) chk("grant_order", 32'(gids[g]), 32'(exp_g[g]));

    // Response back-pressure with another request waiting.
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(1, 8'h3C, 8'h0F, 3'b010, model(1, 8'h3C, 8'h0F, 3'b010));
    set_req(0, 8'h20, 8'h22, 3'b000);
    req_valid[0] = 1'b1;
    check_rsp();
    snap = {1'b0, rsp_valid, rsp_id, rsp_result, rsp_zero};
    snap[11] = rsp_carry;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("hold_rsp", 32'({rsp_carry, rsp_valid, rsp_id, rsp_result, rsp_zero}), 32'(snap));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rsp_drop_bp", 32'(rsp_valid), 32'd0);
    chk("grant_after_accept", 32'(req_ready), 32'b01);
    sb.push_back(model(0, 8'h20, 8'h22, 3'b000));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check_rsp();
    accept_rsp();

    // Operand changes after handshake must not reach the op in flight.
    issue(0, 8'h0F, 8'h00, 3'b101, model(0, 8'h0F, 8'h00, 3'b101));
    set_req(0, 8'hFF, 8'h33, 3'b000);
    check_rsp();
    chk("isolated_result", 32'(rsp_result), 32'hF0);
    accept_rsp();

    // Reset while in EXEC: op dropped, first grant afterwards to requester 0.
    issue(0, 8'h11, 8'h22, 3'b000, model(0, 8'h11, 8'h22, 3'b000));
    rst = 1'b1;
    set_req(0, 8'h44, 8'h04, 3'b001);
    set_req(1, 8'h09, 8'h01, 3'b000);
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_req_ready", 32'(req_ready), 32'd0);
    chk("rst_exec_rsp_result", 32'(rsp_result), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_grant(gid);
    chk("grant_after_reset", 32'(gid), 32'd0);
    chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    if (gid >= 0) begin
      sb.push_back(model(gid, req_a[gid*8 +: 8], req_b[gid*8 +: 8], req_op[gid*3 +: 3]));
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      check_rsp();
      accept_rsp();
    end
    req_valid = '0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
